// File: rtl/cpu_clk_ctrl_pkg.sv
// rtl/cpu_clk_ctrl_pkg.sv - state codes, rate table and divisor helper for cpu_clk_ctrl
package cpu_clk_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } cpu_state_e;

    localparam logic [3:0] RATE_MANUAL = 4'd12;

    function automatic int unsigned rate_hz(input logic [3:0] sel, input int unsigned clk_hz);
        case (sel)
            4'd0:    rate_hz = 1;
            4'd1:    rate_hz = 10;
            4'd2:    rate_hz = 100;
            4'd3:    rate_hz = 1000;
            4'd4:    rate_hz = 10000;
            4'd5:    rate_hz = 100000;
            4'd6:    rate_hz = 1000000;
            4'd7:    rate_hz = 10000000;
            4'd8:    rate_hz = 20000000;
            4'd9:    rate_hz = 25000000;
            4'd10:   rate_hz = 50000000;
            default: rate_hz = clk_hz;
        endcase
    endfunction

    // Only ever called with constant arguments, so the division folds away at elaboration.
    function automatic int unsigned rate_div(input logic [3:0] sel, input int unsigned clk_hz);
        int unsigned d;
        d = clk_hz / rate_hz(sel, clk_hz);
        rate_div = (d == 0) ? 1 : d;
    endfunction

endpackage

// File: rtl/cpu_clk_ctrl_if.sv
// rtl/cpu_clk_ctrl_if.sv - control/status bundle between the clock sequencer and the board
interface cpu_clk_ctrl_if;
    logic [3:0]  rate_sel;
    logic        btn_run;
    logic        btn_step;
    logic        halt_req;
    logic        cpu_ce;
    logic        running;
    logic [1:0]  state;
    logic [31:0] tick_cnt;

    modport master (
        output rate_sel, btn_run, btn_step, halt_req,
        input  cpu_ce, running, state, tick_cnt
    );

    modport slave (
        input  rate_sel, btn_run, btn_step, halt_req,
        output cpu_ce, running, state, tick_cnt
    );
endinterface

// File: rtl/cpu_clk_ctrl_btn_debounce.sv
// rtl/cpu_clk_ctrl_btn_debounce.sv - 2-FF synchronizer, hold-time debouncer and rise-edge pulse
module cpu_clk_ctrl_btn_debounce #(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);
    localparam int DW = $clog2(DEB_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [DW-1:0] cnt;
    logic          accept;

    // cnt holds how many consecutive samples have disagreed with the accepted level.
    assign accept = (sync2 != level) && (cnt == DW'(DEB_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            rise  <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            rise  <= accept && sync2;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (accept) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + DW'(1);
            end
        end
    end
endmodule

// File: rtl/cpu_clk_ctrl.sv
// rtl/cpu_clk_ctrl.sv - run/halt/single-step sequencer issuing a rate-selected clock enable
module cpu_clk_ctrl
    import cpu_clk_ctrl_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 100000000,
    parameter int          DEB_CYCLES   = 1000000,
    parameter bit          RUN_AT_RESET = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    cpu_clk_ctrl_if.slave bus
);
    localparam int         CW       = $clog2(CLK_HZ) + 1;
    localparam cpu_state_e RESET_ST = RUN_AT_RESET ? ST_RUN : ST_HALT;

    cpu_state_e    state_q;
    cpu_state_e    state_n;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_n;
    logic [CW-1:0] div_tab [16];
    logic [3:0]    sel_q;
    logic [3:0]    sel_d;
    logic          sel_chg;
    logic          run_rise;
    logic          step_rise;
    logic          ce_q;
    logic          ce_n;
    logic          running_q;
    logic [31:0]   tick_q;

    for (genvar g = 0; g < 16; g++) begin : g_div
        assign div_tab[g] = CW'(rate_div(4'(g), CLK_HZ));
    end

    cpu_clk_ctrl_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_run_deb (
        .clk   (clk),
        .reset (reset),
        .btn   (bus.btn_run),
        .rise  (run_rise)
    );

    cpu_clk_ctrl_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step_deb (
        .clk   (clk),
        .reset (reset),
        .btn   (bus.btn_step),
        .rise  (step_rise)
    );

    // Switches are registered twice so a change is seen exactly once, one cycle after capture.
    always_ff @(posedge clk) begin
        sel_q <= bus.rate_sel;
        sel_d <= sel_q;
    end
    assign sel_chg = (sel_q != sel_d);

    always_ff @(posedge clk) begin
        if (!reset) state_q <= RESET_ST;
        else        state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        if (bus.halt_req) begin
            state_n = ST_HALT;
        end else begin
            case (state_q)
                ST_HALT: begin
                    if (run_rise && (sel_q < RATE_MANUAL)) state_n = ST_RUN;
                    else if (step_rise)                   state_n = ST_STEP;
                end
                ST_RUN: begin
                    if (run_rise || (sel_q >= RATE_MANUAL)) state_n = ST_HALT;
                end
                default: state_n = ST_HALT;
            endcase
        end
    end

    always_comb begin
        ce_n  = 1'b0;
        cnt_n = cnt_q;
        if (state_n == ST_STEP) begin
            ce_n = 1'b1;
        end else if ((state_q == ST_RUN) && (state_n == ST_RUN) && !sel_chg && (cnt_q == '0)) begin
            ce_n = 1'b1;
        end
        // Entering RUN zeroes the counter so the first pulse follows one cycle later.
        if ((state_q == ST_HALT) && (state_n == ST_RUN)) begin
            cnt_n = '0;
        end else if (sel_chg || ((state_q == ST_RUN) && (cnt_q == '0))) begin
            cnt_n = div_tab[sel_q] - CW'(1);
        end else if (cnt_q != '0) begin
            cnt_n = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q     <= '0;
            ce_q      <= 1'b0;
            running_q <= RUN_AT_RESET;
            tick_q    <= '0;
        end else begin
            cnt_q     <= cnt_n;
            ce_q      <= ce_n;
            running_q <= (state_n == ST_RUN);
            tick_q    <= tick_q + 32'(ce_n);
        end
    end

    assign bus.cpu_ce   = ce_q;
    assign bus.running  = running_q;
    assign bus.state    = state_q;
    assign bus.tick_cnt = tick_q;
endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// tb/tb_cpu_clk_ctrl.sv - vector table, corner sequences and random run against a reference model
module tb_cpu_clk_ctrl;
    // Nominal clock so that rate codes 8..11 divide to 5, 4, 2 and 1.
    localparam int unsigned CLK_HZ = 100000000;
    localparam int          DEB    = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cpu_clk_ctrl_if bus();

    cpu_clk_ctrl #(.CLK_HZ(CLK_HZ), .DEB_CYCLES(DEB), .RUN_AT_RESET(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int sel;
        int cycles;
        int pulses;
        int tick;
        int st;
    } row_t;

    int          total = 0;
    int          bad   = 0;
    int          pulses;
    row_t        rows [4];
    int unsigned freq_tab [12] = '{1, 10, 100, 1000, 10000, 100000, 1000000,
                                   10000000, 20000000, 25000000, 50000000, CLK_HZ};
    int          sel_pool [7]  = '{8, 9, 10, 11, 12, 14, 3};

    int          m_state;
    int          m_wait;
    bit          m_ce;
    logic [31:0] m_tick;
    logic [31:0] t0;
    int          m_sel_q = 0;
    int          m_sel_d = 0;
    bit          m_rise [2];
    bit          m_lvl  [2];
    bit          m_hist [2][16];

    function automatic int ref_div(input int sel);
        int d;
        if (sel >= 12) return 1;
        d = int'(CLK_HZ / freq_tab[sel]);
        return (d < 1) ? 1 : d;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h, want %0h", name, $time, got, exp);
        end
    endtask

    // One clock edge of the reference: buttons are accepted once the last DEB synchronized
    // samples all disagree with the accepted level; the divider counts down to a pulse.
    task automatic model_step(input bit rst, input bit b_run, input bit b_step, input bit halt,
                              input int sel);
        int nxt;
        int div;
        bit chg;
        bit acc;
        bit raw [2];
        raw[0] = b_run;
        raw[1] = b_step;
        if (!rst) begin
            m_state = 1;
            m_wait  = 0;
            m_ce    = 1'b0;
            m_tick  = '0;
            for (int b = 0; b < 2; b++) begin
                m_lvl[b]  = 1'b0;
                m_rise[b] = 1'b0;
                for (int i = 0; i < 16; i++) m_hist[b][i] = 1'b0;
            end
        end else begin
            chg = (m_sel_q != m_sel_d);
            div = ref_div(m_sel_q);
            nxt = m_state;
            if (halt)                                          nxt = 0;
            else if (m_state == 0 && m_rise[0] && m_sel_q < 12) nxt = 1;
            else if (m_state == 1 && m_rise[0])                 nxt = 0;
            else if (m_state == 0 && m_rise[1])                 nxt = 2;
            else if (m_state == 1 && m_sel_q >= 12)             nxt = 0;
            else if (m_state == 2)                              nxt = 0;
            m_ce = (nxt == 2) || (m_state == 1 && nxt == 1 && !chg && m_wait == 0);
            if (m_state == 0 && nxt == 1)             m_wait = 0;
            else if (chg || (m_state == 1 && m_wait == 0)) m_wait = div - 1;
            else if (m_wait > 0)                      m_wait = m_wait - 1;
            m_state = nxt;
            m_tick  = m_tick + 32'(m_ce);
            for (int b = 0; b < 2; b++) begin
                acc = 1'b1;
                for (int i = 1; i <= DEB; i++) if (m_hist[b][i] == m_lvl[b]) acc = 1'b0;
                m_rise[b] = acc && !m_lvl[b];
                if (acc) m_lvl[b] = !m_lvl[b];
                for (int i = 15; i > 0; i--) m_hist[b][i] = m_hist[b][i-1];
                m_hist[b][0] = raw[b];
            end
        end
        m_sel_d = m_sel_q;
        m_sel_q = sel;
    endtask

    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_step(reset, bus.btn_run, bus.btn_step, bus.halt_req, int'(bus.rate_sel));
            @(negedge clk);
            check("ce_run_state", {bus.cpu_ce, bus.running, bus.state},
                  {m_ce, (m_state == 1), 2'(m_state)});
            check("tick", bus.tick_cnt, m_tick);
            if (bus.cpu_ce) pulses++;
        end
    endtask

    task automatic press(input bit is_step, input int hold, input int gap);
        if (is_step) bus.btn_step = 1'b1;
        else         bus.btn_run  = 1'b1;
        cyc(hold);
        bus.btn_step = 1'b0;
        bus.btn_run  = 1'b0;
        cyc(gap);
    endtask

    initial begin
        rows[0] = '{11, 20, 20, 20, 1};
        rows[1] = '{9,  13, 3,  23, 1};
        rows[2] = '{10, 8,  4,  27, 1};
        rows[3] = '{8,  12, 2,  29, 1};

        reset        = 1'b0;
        bus.rate_sel = 4'd11;
        bus.btn_run  = 1'b0;
        bus.btn_step = 1'b0;
        bus.halt_req = 1'b0;
        pulses       = 0;
        cyc(3);
        check("reset_state", {bus.cpu_ce, bus.state, bus.tick_cnt}, {1'b0, 2'd1, 32'd0});
        reset = 1'b1;

        for (int i = 0; i < 4; i++) begin
            bus.rate_sel = 4'(rows[i].sel);
            pulses = 0;
            cyc(rows[i].cycles);
            check($sformatf("row%0d_pulses", i), pulses, rows[i].pulses);
            check($sformatf("row%0d_tick", i), bus.tick_cnt, rows[i].tick);
            check($sformatf("row%0d_state", i), bus.state, rows[i].st);
        end

        press(1'b0, 2, 8);
        check("short_run_press", bus.state, 2'd1);
        press(1'b0, 6, 8);
        check("run_press_halts", bus.state, 2'd0);
        pulses = 0;
        cyc(5);
        check("halt_quiet", pulses, 0);
        t0 = m_tick;
        for (int i = 0; i < 3; i++) press(1'b1, 6, 8);
        check("three_steps", pulses, 3);
        check("three_steps_tick", bus.tick_cnt, t0 + 32'd3);

        pulses = 0;
        bus.halt_req = 1'b1;
        press(1'b0, 6, 8);
        bus.halt_req = 1'b0;
        cyc(3);
        check("halt_beats_run", bus.state, 2'd0);
        check("halt_beats_run_ce", pulses, 0);

        bus.rate_sel = 4'd10;
        cyc(2);
        press(1'b0, 6, 8);
        check("run_again", bus.state, 2'd1);
        bus.rate_sel = 4'd13;
        cyc(4);
        check("manual_halts", bus.state, 2'd0);
        pulses = 0;
        press(1'b0, 6, 8);
        check("manual_run_ignored", {bus.state, 8'(pulses)}, {2'd0, 8'd0});
        press(1'b1, 6, 8);
        check("manual_step", pulses, 1);

        force dut.tick_q = 32'hFFFF_FFFE;
        m_tick = 32'hFFFF_FFFE;
        cyc(1);
        release dut.tick_q;
        for (int i = 0; i < 3; i++) press(1'b1, 6, 8);
        check("tick_wrap", bus.tick_cnt, 32'd1);

        bus.rate_sel = 4'd11;
        cyc(2);
        press(1'b0, 6, 8);
        check("ce_before_reset", {bus.state, bus.cpu_ce}, {2'd1, 1'b1});
        reset = 1'b0;
        cyc(1);
        check("reset_mid_pulse", {bus.cpu_ce, bus.state, bus.tick_cnt}, {1'b0, 2'd1, 32'd0});
        reset = 1'b1;
        cyc(3);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) bus.btn_run  = ~bus.btn_run;
            if ($urandom_range(0, 5) == 0) bus.btn_step = ~bus.btn_step;
            if ($urandom_range(0, 49) == 0) bus.rate_sel = 4'(sel_pool[$urandom_range(0, 6)]);
            bus.halt_req = ($urandom_range(0, 39) == 0);
            reset        = ($urandom_range(0, 599) != 0);
            cyc(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
